core_wb_arbiter: RTL and testbench

//  Writer side of the core register file write port (a2/wd2/we2). Merges single-cycle ALU

---
 rtl/core_wb_arbiter_if.sv | 41 ++++
 rtl/core_wb_arbiter.sv | 173 +++++++++++++++++
 tb/tb_core_wb_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/core_wb_arbiter_if.sv
// Bundles decode issue/query, ALU and LSU result handshakes, and the regfile write port.
// master = producers/consumers around the arbiter; slave = the arbiter itself.
interface core_wb_arbiter_if #(
    parameter int XLEN = 32
);
    logic            iss_valid;
    logic            iss_long;
    logic [4:0]      iss_rd;
    logic [4:0]      q0;
    logic [4:0]      q1;
    logic [4:0]      q2;
    logic            busy0;
    logic            busy1;
    logic            busy2;

    logic            alu_valid;
    logic            alu_ready;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_wd;

    logic            lsu_valid;
    logic            lsu_ready;
    logic [4:0]      lsu_rd;
    logic [XLEN-1:0] lsu_wd;

    logic [4:0]      rf_a2;
    logic [XLEN-1:0] rf_wd2;
    logic            rf_we2;

    modport master (
        output iss_valid, iss_long, iss_rd, q0, q1, q2,
        output alu_valid, alu_rd, alu_wd, lsu_valid, lsu_rd, lsu_wd,
        input  busy0, busy1, busy2, alu_ready, lsu_ready, rf_a2, rf_wd2, rf_we2
    );

    modport slave (
        input  iss_valid, iss_long, iss_rd, q0, q1, q2,
        input  alu_valid, alu_rd, alu_wd, lsu_valid, lsu_rd, lsu_wd,
        output busy0, busy1, busy2, alu_ready, lsu_ready, rf_a2, rf_wd2, rf_we2
    );
endinterface

// File: rtl/core_wb_arbiter.sv
// Regfile write-port arbiter: ALU results direct, long-op results through a FIFO, pending-write scoreboard.
// Latency: ALU 0 cycles (combinational to rf_*), long-op >=1 cycle; ALU stalled one cycle when FIFO head starves.
package core_wb_pkg;
    typedef struct packed {
        int unsigned XLEN;
    } config_t;
    localparam config_t DEFAULT_CONF = '{XLEN: 32};
endpackage

// Small generic FIFO with registered occupancy count.
// Latency 1 cycle (push visible at head next cycle); caller must not push when full nor pop when empty.
module wb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
endmodule

module core_wb_arbiter
    import core_wb_pkg::*;
#(
    parameter config_t CONF         = DEFAULT_CONF,
    parameter int      FIFO_DEPTH   = 2,
    parameter int      STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    core_wb_arbiter_if.slave   wb
);
    localparam int XLEN = int'(CONF.XLEN);
    localparam int SCW  = $clog2(STARVE_LIMIT) + 1;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] wd;
    } wb_ent_t;

    typedef enum logic {NORMAL, DRAIN} state_t;

    state_t           state, state_nxt;
    logic [SCW-1:0]   starve_cnt, starve_nxt;
    logic [31:0]      sb;
    logic [31:0]      sb_set, sb_clr;
    wb_ent_t          push_ent, head;
    logic             fifo_full, fifo_empty, push, pop;
    logic             sel_vld, from_fifo;
    logic [4:0]       sel_rd;
    logic [XLEN-1:0]  sel_wd;
    logic             we;

    assign wb.lsu_ready = !fifo_full;
    assign push         = wb.lsu_valid && !fifo_full;
    assign push_ent     = '{rd: wb.lsu_rd, wd: wb.lsu_wd};

    wb_fifo #(.WIDTH($bits(wb_ent_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (push_ent),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= NORMAL;
            starve_cnt <= '0;
            sb         <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            sb         <= ((sb & ~sb_clr) | sb_set) & ~32'd1;
        end
    end

    always_comb begin
        state_nxt    = state;
        starve_nxt   = starve_cnt;
        wb.alu_ready = 1'b1;
        pop          = 1'b0;
        sel_vld      = 1'b0;
        from_fifo    = 1'b0;
        sel_rd       = '0;
        sel_wd       = '0;
        case (state)
            NORMAL: begin
                if (wb.alu_valid) begin
                    sel_vld = 1'b1;
                    sel_rd  = wb.alu_rd;
                    sel_wd  = wb.alu_wd;
                    if (fifo_empty) begin
                        starve_nxt = '0;
                    end else if (starve_cnt == SCW'(STARVE_LIMIT - 1)) begin
                        state_nxt = DRAIN;
                    end else begin
                        starve_nxt = starve_cnt + 1'b1;
                    end
                end else begin
                    starve_nxt = '0;
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        from_fifo = 1'b1;
                        sel_vld   = 1'b1;
                        sel_rd    = head.rd;
                        sel_wd    = head.wd;
                    end
                end
            end
            DRAIN: begin
                // ALU holds its result while the starved head goes out
                wb.alu_ready = 1'b0;
                starve_nxt   = '0;
                state_nxt    = NORMAL;
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    from_fifo = 1'b1;
                    sel_vld   = 1'b1;
                    sel_rd    = head.rd;
                    sel_wd    = head.wd;
                end
            end
            default: state_nxt = NORMAL;
        endcase
    end

    assign we        = sel_vld && (sel_rd != 5'd0);
    assign wb.rf_we2 = we;
    assign wb.rf_a2  = sel_rd;
    assign wb.rf_wd2 = sel_wd;

    assign sb_set = (wb.iss_valid && wb.iss_long) ? (32'd1 << wb.iss_rd) : 32'd0;
    assign sb_clr = (we && from_fifo) ? (32'd1 << sel_rd) : 32'd0;

    assign wb.busy0 = sb[wb.q0];
    assign wb.busy1 = sb[wb.q1];
    assign wb.busy2 = sb[wb.q2];
endmodule

// File: tb/tb_core_wb_arbiter.sv
// Directed bench for core_wb_arbiter: vector table for the ALU path, hand sequences for FIFO/starvation/reset.
module tb_core_wb_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    core_wb_arbiter_if #(.XLEN(32)) wb ();

    core_wb_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (wb)
    );

    typedef struct {
        string       name;
        logic        alu_valid;
        logic [4:0]  alu_rd;
        logic [31:0] alu_wd;
        logic        exp_we;
        logic [4:0]  exp_a2;
        logic [31:0] exp_wd;
        logic        exp_ardy;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    // Decode must never issue a long op to a destination that is still pending.
    always @(posedge clk) begin
        if (rst_n && wb.iss_valid && wb.iss_long)
            assert (!wb.busy2) else $error("FAIL iss_pending: long op issued to busy rd %0d", wb.iss_rd);
    end

    initial begin
        vecs[0] = '{"alu_rd5",   1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 5'd5,  32'hDEADBEEF, 1'b1};
        vecs[1] = '{"alu_x0",    1'b1, 5'd0,  32'h00001234, 1'b0, 5'd0,  32'h00001234, 1'b1};
        vecs[2] = '{"alu_idle",  1'b0, 5'd9,  32'h0000CAFE, 1'b0, 5'd0,  32'h00000000, 1'b1};
        vecs[3] = '{"alu_rd31",  1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd31, 32'hFFFFFFFF, 1'b1};
        vecs[4] = '{"alu_zero",  1'b1, 5'd1,  32'h00000000, 1'b1, 5'd1,  32'h00000000, 1'b1};
        vecs[5] = '{"alu_idle2", 1'b0, 5'd0,  32'h00000000, 1'b0, 5'd0,  32'h00000000, 1'b1};

        wb.iss_valid = 0; wb.iss_long = 0; wb.iss_rd = 0;
        wb.q0 = 0; wb.q1 = 0; wb.q2 = 0;
        wb.alu_valid = 0; wb.alu_rd = 0; wb.alu_wd = 0;
        wb.lsu_valid = 0; wb.lsu_rd = 0; wb.lsu_wd = 0;

        // reset state
        #1;
        chk("rst_we2",  wb.rf_we2, 1'b0);
        chk("rst_lrdy", wb.lsu_ready, 1'b1);
        chk("rst_ardy", wb.alu_ready, 1'b1);
        chk("rst_busy", {wb.busy0, wb.busy1, wb.busy2}, 3'b000);
        nxt();
        rst_n = 1'b1;

        // single-cycle ALU path, FIFO empty
        foreach (vecs[i]) begin
            nxt();
            wb.alu_valid = vecs[i].alu_valid;
            wb.alu_rd    = vecs[i].alu_rd;
            wb.alu_wd    = vecs[i].alu_wd;
            #1;
            chk({vecs[i].name, "_we"},   wb.rf_we2,    vecs[i].exp_we);
            chk({vecs[i].name, "_a2"},   wb.rf_a2,     vecs[i].exp_a2);
            chk({vecs[i].name, "_wd"},   wb.rf_wd2,    vecs[i].exp_wd);
            chk({vecs[i].name, "_ardy"}, wb.alu_ready, vecs[i].exp_ardy);
        end

        // long op: scoreboard set, FIFO latency, scoreboard clear
        nxt();
        wb.alu_valid = 0;
        wb.iss_valid = 1; wb.iss_long = 1; wb.iss_rd = 7; wb.q0 = 7; wb.q2 = 7;
        #1 chk("busy7_pre", wb.busy0, 1'b0);
        nxt();
        wb.iss_valid = 0; wb.iss_long = 0;
        wb.lsu_valid = 1; wb.lsu_rd = 7; wb.lsu_wd = 32'h55;
        #1;
        chk("busy7_set", wb.busy0, 1'b1);
        chk("push_lrdy", wb.lsu_ready, 1'b1);
        chk("push_nowr", wb.rf_we2, 1'b0);
        nxt();
        wb.lsu_valid = 0;
        #1;
        chk("lsu_we",   wb.rf_we2, 1'b1);
        chk("lsu_a2",   wb.rf_a2,  5'd7);
        chk("lsu_wd",   wb.rf_wd2, 32'h55);
        chk("busy7_wr", wb.busy0,  1'b1);
        nxt();
        #1;
        chk("busy7_clr", wb.busy0,  1'b0);
        chk("lsu_done",  wb.rf_we2, 1'b0);

        // FIFO fill under ALU pressure, starvation drain
        nxt();
        wb.alu_valid = 1; wb.alu_rd = 3; wb.alu_wd = 32'hA1A1A1A1;
        wb.lsu_valid = 1; wb.lsu_rd = 8; wb.lsu_wd = 32'h88;
        #1;
        chk("A_lrdy", wb.lsu_ready, 1'b1);
        chk("A_a2",   wb.rf_a2, 5'd3);
        nxt();
        wb.lsu_rd = 9; wb.lsu_wd = 32'h99;
        #1;
        chk("B_lrdy", wb.lsu_ready, 1'b1);
        chk("B_a2",   wb.rf_a2, 5'd3);
        nxt();
        wb.lsu_rd = 10; wb.lsu_wd = 32'h1010;
        #1;
        chk("C_full", wb.lsu_ready, 1'b0);
        chk("C_ardy", wb.alu_ready, 1'b1);
        nxt();
        #1;
        chk("D_full", wb.lsu_ready, 1'b0);
        chk("D_ardy", wb.alu_ready, 1'b1);
        nxt();
        #1;
        chk("E_ardy", wb.alu_ready, 1'b1);
        chk("E_a2",   wb.rf_a2, 5'd3);
        nxt();
        #1;
        chk("drain_ardy", wb.alu_ready, 1'b0);
        chk("drain_we",   wb.rf_we2, 1'b1);
        chk("drain_a2",   wb.rf_a2, 5'd8);
        chk("drain_wd",   wb.rf_wd2, 32'h88);
        chk("drain_full", wb.lsu_ready, 1'b0);
        nxt();
        #1;
        chk("G_ardy", wb.alu_ready, 1'b1);
        chk("G_a2",   wb.rf_a2, 5'd3);
        chk("G_wd",   wb.rf_wd2, 32'hA1A1A1A1);
        chk("G_lrdy", wb.lsu_ready, 1'b1);
        nxt();
        wb.alu_valid = 0; wb.lsu_valid = 0;
        #1;
        chk("H_a2", wb.rf_a2, 5'd9);
        chk("H_wd", wb.rf_wd2, 32'h99);
        nxt();
        #1;
        chk("I_a2", wb.rf_a2, 5'd10);
        chk("I_wd", wb.rf_wd2, 32'h1010);
        nxt();
        #1 chk("J_we", wb.rf_we2, 1'b0);

        // reset with two buffered entries and a pending bit
        nxt();
        wb.alu_valid = 1; wb.alu_rd = 4; wb.alu_wd = 32'h4;
        wb.lsu_valid = 1; wb.lsu_rd = 11; wb.lsu_wd = 32'hB;
        wb.iss_valid = 1; wb.iss_long = 1; wb.iss_rd = 7; wb.q0 = 7; wb.q2 = 7;
        nxt();
        wb.iss_valid = 0; wb.iss_long = 0;
        wb.lsu_rd = 12; wb.lsu_wd = 32'hC;
        #1 chk("K_busy7", wb.busy0, 1'b1);
        nxt();
        wb.lsu_valid = 0;
        #1 chk("K_full", wb.lsu_ready, 1'b0);
        wb.alu_valid = 0;
        rst_n = 1'b0;
        #1;
        chk("rst2_we2",  wb.rf_we2, 1'b0);
        chk("rst2_lrdy", wb.lsu_ready, 1'b1);
        chk("rst2_ardy", wb.alu_ready, 1'b1);
        chk("rst2_busy", {wb.busy0, wb.busy1, wb.busy2}, 3'b000);
        nxt();
        rst_n = 1'b1;
        #1 chk("post_rst_we", wb.rf_we2, 1'b0);
        nxt();
        #1 chk("post_rst_we2", wb.rf_we2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
